// File: rtl/audio_pkg.sv
// Shared audio-subsystem constants and the I2S receiver state encoding.
package audio_pkg;
  localparam int SAMPLE_W = 24;
  localparam int MIN_BITS = 16;
  localparam int BITCNT_W = 6;

  typedef enum logic {
    RX_HUNT = 1'b0,
    RX_RUN  = 1'b1
  } rx_state_e;
endpackage

// File: rtl/i2s_rx_sync2.sv
// Generic two-flop synchroniser for a single asynchronous level.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ff_q <= '0;
    else      ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];
endmodule

// File: rtl/i2s_rx.sv
// Oversampling I2S receiver: deserialises BCK/LRCK/DATA into left-justified
// stereo samples with a pair-valid strobe and a short-slot error strobe.
module i2s_rx #(
  parameter int SAMPLE_W = 24,
  parameter int MIN_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                i2s_bck,
  input  logic                i2s_lrck,
  input  logic                i2s_data,
  output logic [SAMPLE_W-1:0] left_data,
  output logic [SAMPLE_W-1:0] right_data,
  output logic                sample_valid,
  output logic                word_error
);
  import audio_pkg::BITCNT_W;
  import audio_pkg::rx_state_e;
  import audio_pkg::RX_HUNT;
  import audio_pkg::RX_RUN;

  logic bck_s, lrck_s, data_s;

  sync2 u_sync_bck  (.clk(clk), .rst(rst), .d_i(i2s_bck),  .q_o(bck_s));
  sync2 u_sync_lrck (.clk(clk), .rst(rst), .d_i(i2s_lrck), .q_o(lrck_s));
  sync2 u_sync_data (.clk(clk), .rst(rst), .d_i(i2s_data), .q_o(data_s));

  // Edge stage: the detected rise travels with the lrck/data sampled alongside it.
  logic bck_d_q, rise_q, lrck_q, data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bck_d_q <= 1'b0;
      rise_q  <= 1'b0;
      lrck_q  <= 1'b0;
      data_q  <= 1'b0;
    end else begin
      bck_d_q <= bck_s;
      rise_q  <= bck_s & ~bck_d_q;
      lrck_q  <= lrck_s;
      data_q  <= data_s;
    end
  end

  logic [SAMPLE_W-1:0] shreg_q, shreg_wr;
  logic [BITCNT_W-1:0] bitcnt_q, cnt_inc;
  logic                ws_q;
  logic                boundary, short_w;

  always_comb begin
    shreg_wr = shreg_q;
    for (int i = 0; i < SAMPLE_W; i++)
      if (bitcnt_q == BITCNT_W'(SAMPLE_W - 1 - i)) shreg_wr[i] = data_q;
    cnt_inc = (bitcnt_q == '1) ? bitcnt_q : bitcnt_q + 1'b1;
  end

  // A word select change at a rise means this bit is the LSB of channel ws_q.
  assign boundary = rise_q & (lrck_q != ws_q);
  assign short_w  = cnt_inc < BITCNT_W'(MIN_BITS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
      ws_q     <= 1'b0;
    end else if (rise_q) begin
      ws_q <= lrck_q;
      if (boundary) begin
        shreg_q  <= '0;
        bitcnt_q <= '0;
      end else begin
        shreg_q  <= shreg_wr;
        bitcnt_q <= cnt_inc;
      end
    end
  end

  rx_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RX_HUNT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) state_d = RX_HUNT;
    else if (boundary) begin
      unique case (state_q)
        RX_HUNT: state_d = RX_RUN;
        RX_RUN:  if (short_w) state_d = RX_HUNT;
        default: state_d = RX_HUNT;
      endcase
    end
  end

  logic commit_l, commit_r, err_w;

  always_comb begin
    commit_l = 1'b0;
    commit_r = 1'b0;
    err_w    = 1'b0;
    if (enable && boundary && state_q == RX_RUN) begin
      if (short_w)   err_w    = 1'b1;
      else if (ws_q) commit_r = 1'b1;
      else           commit_l = 1'b1;
    end
  end

  logic [SAMPLE_W-1:0] left_q, left_d, right_q, right_d;
  logic                valid_q, valid_d, err_q, err_d, left_ok_q, left_ok_d;

  always_comb begin
    left_d    = commit_l ? shreg_wr : left_q;
    right_d   = commit_r ? shreg_wr : right_q;
    valid_d   = commit_r & left_ok_q;
    err_d     = err_w;
    left_ok_d = left_ok_q;
    if (!enable || state_q == RX_HUNT) left_ok_d = 1'b0;
    else if (commit_l)                 left_ok_d = 1'b1;
    else if (commit_r || err_w)        left_ok_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      left_ok_q <= 1'b0;
    end else begin
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      left_ok_q <= left_ok_d;
    end
  end

  assign left_data    = left_q;
  assign right_data   = right_q;
  assign sample_valid = valid_q;
  assign word_error   = err_q;
endmodule
